// File: rtl/matmul_nxn_kstream.sv
// ---------------------------------------------------------------------------
// matmul_nxn_kstream
//
// NxN integer matrix-multiply engine, C = A*B, with A NxK and B KxN. The
// inner dimension K is chosen per job (up to K_MAX). It is streamed as one
// outer-product beat per cycle: column k of A and row k of B arrive together.
// Every C[i][j] does a single-cycle multiply-add on each accepted beat.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         begin a job (sampled only in IDLE)
//   k_len         beats in the job, clamped to K_MAX (sampled with start)
//   acc_mode      1: accumulate onto existing C, 0: clear C first
//   signed_mode   1: two's-complement operands, 0: unsigned
//   in_valid      beat valid; accepted when in_valid & in_ready
//   in_ready      high in LOAD only
//   a_col, b_row  column k of A / row k of B, element i at [i*DATA_W +: DATA_W]
//   c_out         accumulators, C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
//   busy          high in LOAD and DONE
//   done          one-cycle pulse, c_out is final
//   ovf           sticky overflow for the current job
// ---------------------------------------------------------------------------
module matmul_nxn_kstream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int N      = 2,
  parameter int K_MAX  = 16,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    acc_mode,
  input  logic                    signed_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_W-1:0]     a_col,
  input  logic [N*DATA_W-1:0]     b_row,
  output logic [N*N*ACC_W-1:0]    c_out,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [KW-1:0] K_MAX_W = KW'(K_MAX);

  logic [1:0]              state;
  logic [KW-1:0]           k_reg;
  logic [KW-1:0]           cnt;
  logic                    sgn;
  logic [ACC_W-1:0]        acc      [N*N];

  logic [KW-1:0]           k_clamp;
  logic [2*DATA_W-1:0]     a_ext    [N];
  logic [2*DATA_W-1:0]     b_ext    [N];
  logic [2*DATA_W-1:0]     prod     [N*N];
  logic [ACC_W-1:0]        prod_ext [N*N];
  logic [ACC_W:0]          sum      [N*N];
  logic [N*N-1:0]          add_ovf;
  logic                    any_ovf;

  assign k_clamp  = (k_len > K_MAX_W) ? K_MAX_W : k_len;
  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == DONE);
  assign done     = (state == DONE);

  // Operand extension and MAC datapath. The low 2*DATA_W bits of the product
  // of the extended operands are exact in both modes, so one multiplier
  // serves signed and unsigned jobs.
  // NOTE: every variable written here gets a value on every path; a missed
  // branch in always_comb would otherwise infer a latch.
  always_comb begin
    add_ovf = '0;
    c_out   = '0;
    for (int i = 0; i < N; i++) begin
      if (sgn) begin
        a_ext[i] = {{DATA_W{a_col[i*DATA_W+DATA_W-1]}}, a_col[i*DATA_W +: DATA_W]};
        b_ext[i] = {{DATA_W{b_row[i*DATA_W+DATA_W-1]}}, b_row[i*DATA_W +: DATA_W]};
      end else begin
        a_ext[i] = {{DATA_W{1'b0}}, a_col[i*DATA_W +: DATA_W]};
        b_ext[i] = {{DATA_W{1'b0}}, b_row[i*DATA_W +: DATA_W]};
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i*N+j] = a_ext[i] * b_ext[j];
        if (sgn) prod_ext[i*N+j] = ACC_W'($signed(prod[i*N+j]));
        else     prod_ext[i*N+j] = ACC_W'(prod[i*N+j]);
        sum[i*N+j] = {1'b0, acc[i*N+j]} + {1'b0, prod_ext[i*N+j]};
        // Signed: operands agree in sign but the result does not.
        // Unsigned: carry out of the top bit.
        if (sgn)
          add_ovf[i*N+j] = (acc[i*N+j][ACC_W-1] == prod_ext[i*N+j][ACC_W-1]) &&
                           (sum[i*N+j][ACC_W-1] != acc[i*N+j][ACC_W-1]);
        else
          add_ovf[i*N+j] = sum[i*N+j][ACC_W];
        c_out[(i*N+j)*ACC_W +: ACC_W] = acc[i*N+j];
      end
    end
  end

  assign any_ovf = |add_ovf;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values and the block order cannot create races.
  // NOTE: the accumulators are reset too, not just the control, because
  // c_out must read 0 after reset and must not leak an abandoned job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k_reg <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      ovf   <= 1'b0;
      for (int e = 0; e < N*N; e++) acc[e] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_reg <= k_clamp;
            sgn   <= signed_mode;
            cnt   <= '0;
            ovf   <= 1'b0;
            if (!acc_mode) begin
              for (int e = 0; e < N*N; e++) acc[e] <= '0;
            end
            state <= (k_clamp == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            for (int e = 0; e < N*N; e++) acc[e] <= sum[e][ACC_W-1:0];
            ovf <= ovf | any_ovf;
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == k_reg) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_kstream.sv
// ---------------------------------------------------------------------------
// tb_matmul_nxn_kstream
//
// Drives two engines from the same stimulus: the default ACC_W=32 build and
// an ACC_W=16 build that can be pushed into overflow. Expected results come
// from an integer reference model. Each add is done in wide signed arithmetic,
// range-checked for overflow, then reduced modulo 2^ACC_W. Inputs change and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_matmul_nxn_kstream;

  localparam int DATA_W = 8;
  localparam int N      = 2;
  localparam int K_MAX  = 16;
  localparam int KW     = $clog2(K_MAX + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              acc_mode;
  logic              signed_mode;
  logic              in_valid;
  logic [15:0]       a_col;
  logic [15:0]       b_row;
  logic              in_ready,  in_ready16;
  logic [127:0]      c32;
  logic [63:0]       c16;
  logic              busy,  busy16;
  logic              done,  done16;
  logic              ovf32, ovf16;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: raw ACC_W-bit values, non-negative.
  longint mc32 [4];
  longint mc16 [4];
  bit     mo32, mo16;

  // Beat storage for the current job: ja[k][i] is A[i][k], jb[k][j] is B[k][j].
  logic [7:0] ja [K_MAX+4][2];
  logic [7:0] jb [K_MAX+4][2];

  always #5 clk = ~clk;

  matmul_nxn_kstream #(.DATA_W(DATA_W), .ACC_W(32), .N(N), .K_MAX(K_MAX)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .c_out(c32), .busy(busy), .done(done),
    .ovf(ovf32));

  matmul_nxn_kstream #(.DATA_W(DATA_W), .ACC_W(16), .N(N), .K_MAX(K_MAX)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready16),
    .a_col(a_col), .b_row(b_row), .c_out(c16), .busy(busy16), .done(done16),
    .ovf(ovf16));

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint raw32(input int v);
    return longint'(v) & 64'hFFFF_FFFF;
  endfunction

  // One multiply-add on a model accumulator of width w.
  function automatic longint model_mac(input longint cur_raw, input int w, input bit sgn,
                                       input logic [7:0] a, input logic [7:0] b,
                                       output bit ov);
    longint m, cur, p, s, lo, hi;
    m = longint'(1) << w;
    if (sgn) begin
      cur = (cur_raw >= m / 2) ? cur_raw - m : cur_raw;
      p   = longint'($signed(a)) * longint'($signed(b));
      lo  = -(m / 2);
      hi  = m / 2 - 1;
    end else begin
      cur = cur_raw;
      p   = longint'(a) * longint'(b);
      lo  = 0;
      hi  = m - 1;
    end
    s  = cur + p;
    ov = (s < lo) || (s > hi);
    s  = s % m;
    if (s < 0) s += m;
    return s;
  endfunction

  task automatic check_results(input string tag);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s_c32[%0d]", tag, e), longint'(c32[e*32 +: 32]), mc32[e]);
      check($sformatf("%s_c16[%0d]", tag, e), longint'(c16[e*16 +: 16]), mc16[e]);
    end
    check({tag, "_ovf32"}, longint'(ovf32), longint'(mo32));
    check({tag, "_ovf16"}, longint'(ovf16), longint'(mo16));
  endtask

  // Run one job from IDLE using ja/jb. Ends on the falling edge of the done
  // cycle. With poke set, start and in_valid are pulsed in DONE and IDLE
  // afterwards and must have no effect.
  task automatic run_job(input string tag, input int k, input bit accm, input bit sgn,
                         input int gap, input bit poke);
    int ke;
    bit ov;
    ke = (k > K_MAX) ? K_MAX : k;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); acc_mode = accm; signed_mode = sgn;
    if (!accm) begin
      for (int e = 0; e < 4; e++) begin mc32[e] = 0; mc16[e] = 0; end
    end
    mo32 = 1'b0; mo16 = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < ke; b++) begin
      check({tag, "_ready"}, longint'(in_ready), 1);
      check({tag, "_done_early"}, longint'(done), 0);
      a_col = {ja[b][1], ja[b][0]};
      b_row = {jb[b][1], jb[b][0]};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a_col = 16'($urandom);
      b_row = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          mc32[i*2+j] = model_mac(mc32[i*2+j], 32, sgn, ja[b][i], jb[b][j], ov);
          mo32 |= ov;
          mc16[i*2+j] = model_mac(mc16[i*2+j], 16, sgn, ja[b][i], jb[b][j], ov);
          mo16 |= ov;
        end
      end
      if (b < ke - 1) begin
        repeat (gap) begin
          check({tag, "_stall_done"}, longint'(done), 0);
          @(negedge clk);
        end
      end
    end
    check({tag, "_done"}, longint'(done), 1);
    check({tag, "_busy"}, longint'(busy), 1);
    check_results(tag);
    if (poke) begin
      start = 1'b1; in_valid = 1'b1; k_len = KW'(3); acc_mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_poke_busy"}, longint'(busy), 0);
      check({tag, "_poke_done"}, longint'(done), 0);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_idle_busy"}, longint'(busy), 0);
      check({tag, "_idle_ready"}, longint'(in_ready), 0);
      check_results({tag, "_poked"});
    end
  endtask

  task automatic load_basic();
    ja[0][0] = 8'd1; ja[0][1] = 8'd3; jb[0][0] = 8'd5; jb[0][1] = 8'd6;
    ja[1][0] = 8'd2; ja[1][1] = 8'd4; jb[1][0] = 8'd7; jb[1][1] = 8'd8;
  endtask

  task automatic check_const(input string tag, input int c0, input int c1,
                             input int c2, input int c3);
    check({tag, "_k00"}, longint'(c32[31:0]),   raw32(c0));
    check({tag, "_k01"}, longint'(c32[63:32]),  raw32(c1));
    check({tag, "_k10"}, longint'(c32[95:64]),  raw32(c2));
    check({tag, "_k11"}, longint'(c32[127:96]), raw32(c3));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; acc_mode = 1'b0; signed_mode = 1'b0;
    in_valid = 1'b0; a_col = '0; b_row = '0;
    for (int e = 0; e < 4; e++) begin mc32[e] = 0; mc16[e] = 0; end
    mo32 = 1'b0; mo16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_c32", longint'(c32[63:0]) | longint'(c32[127:64]), 0);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_ovf", longint'(ovf32), 0);
    rst = 1'b0;

    // Basic signed job, then the same job accumulated, with pokes after.
    load_basic();
    run_job("basic", 2, 1'b0, 1'b1, 0, 1'b1);
    check_const("basic", 19, 22, 43, 50);
    run_job("accum", 2, 1'b1, 1'b1, 0, 1'b0);
    check_const("accum", 38, 44, 86, 100);

    // Handshake gaps: prior result cleared, same C.
    run_job("gaps", 2, 1'b0, 1'b1, 3, 1'b1);
    check_const("gaps", 19, 22, 43, 50);

    // k_len=0 with accumulate: C unchanged, done the cycle after start.
    run_job("k0", 0, 1'b1, 1'b1, 0, 1'b0);
    check_const("k0", 19, 22, 43, 50);

    // Signed operands.
    ja[0][0] = 8'hFF; ja[0][1] = 8'd3; jb[0][0] = 8'd5; jb[0][1] = 8'd6;
    ja[1][0] = 8'd2;  ja[1][1] = 8'hFC; jb[1][0] = 8'd7; jb[1][1] = 8'd8;
    run_job("signed", 2, 1'b0, 1'b1, 0, 1'b0);
    check_const("signed", 9, 10, -13, -14);

    // Unsigned and signed extremes.
    ja[0][0] = 8'hFF; ja[0][1] = 8'hFF; jb[0][0] = 8'hFF; jb[0][1] = 8'hFF;
    run_job("uext", 1, 1'b0, 1'b0, 0, 1'b0);
    check_const("uext", 65025, 65025, 65025, 65025);
    run_job("sext", 1, 1'b0, 1'b1, 0, 1'b0);
    check_const("sext", 1, 1, 1, 1);

    // 3 * 127*127 overflows signed 16 bits but not 32 bits.
    for (int b = 0; b < 3; b++) begin
      ja[b][0] = 8'd127; ja[b][1] = 8'd127; jb[b][0] = 8'd127; jb[b][1] = 8'd127;
    end
    run_job("ovf", 3, 1'b0, 1'b1, 0, 1'b0);
    check("ovf_dut16", longint'(ovf16), 1);
    check("ovf_dut32", longint'(ovf32), 0);

    // Randomised jobs, including k_len above K_MAX (clamped).
    for (int t = 0; t < 40; t++) begin
      int k;
      k = $urandom_range(0, 20);
      for (int b = 0; b < K_MAX; b++) begin
        for (int i = 0; i < 2; i++) begin
          ja[b][i] = 8'($urandom);
          jb[b][i] = 8'($urandom);
        end
      end
      run_job($sformatf("rnd%0d", t), k, 1'($urandom), 1'($urandom),
              $urandom_range(0, 2), 1'($urandom));
    end

    // Reset after the first beat: job abandoned, everything back to zero.
    load_basic();
    @(negedge clk);
    start = 1'b1; k_len = KW'(2); acc_mode = 1'b0; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_col = {ja[0][1], ja[0][0]}; b_row = {jb[0][1], jb[0][0]}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_c00_nonzero", longint'(c32[31:0] != 0), 1);
    rst = 1'b1;
    #1;
    check("mrst_c32", longint'(c32[63:0]) | longint'(c32[127:64]), 0);
    check("mrst_ready", longint'(in_ready), 0);
    check("mrst_busy", longint'(busy), 0);
    check("mrst_done", longint'(done), 0);
    check("mrst_ovf", longint'(ovf32), 0);
    @(negedge clk);
    rst = 1'b0;
    a_col = {ja[1][1], ja[1][0]}; b_row = {jb[1][1], jb[1][0]}; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_done", longint'(done), 0);
      check("mrst_stay0", longint'(c32[31:0]), 0);
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_nxn_kstream.md
# matmul_nxn_kstream

Parametrised NxN integer matrix-multiply engine: the next generation of the fixed 2x2 `matmul_2x2_kN` unit. It computes C = A·B (A is NxK, B is KxN), with K chosen at run time up to K_MAX. The K dimension is streamed one outer-product beat per cycle over a valid/ready handshake. It adds signed/unsigned operand mode, accumulate-onto-previous-result mode and a sticky overflow flag, and sits between the operand fetch logic and the result writeback path of the accelerator.

## Interface
- DATA_W, 8, operand element width
- ACC_W, 32, accumulator/result element width; must be ≥ 2·DATA_W + $clog2(K_MAX)
- N, 2, matrix dimension (N ≥ 1)
- K_MAX, 16, maximum inner dimension per job
- Width abbreviation: KW = $clog2(K_MAX+1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin job; sampled only in IDLE
- k_len  in  KW  beats in job; sampled with start; values > K_MAX are clamped to K_MAX
- acc_mode  in  1  1: add onto existing C; 0: clear C first; sampled with start
- signed_mode  in  1  1: operands two's complement; 0: unsigned; sampled with start
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- a_col  in  N·DATA_W  column k of A; element i at [i·DATA_W +: DATA_W]
- b_row  in  N·DATA_W  row k of B; element j at [j·DATA_W +: DATA_W]
- c_out  out  N·N·ACC_W  result; C[i][j] at [(i·N+j)·ACC_W +: ACC_W]
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse; c_out is final
- ovf  out  1  sticky overflow for the current job

## Operation
- States: IDLE, LOAD, DONE.
- IDLE → LOAD on start. On that edge the block latches k_len (clamped), signed_mode and beat counter = 0. If acc_mode=0, it clears all accumulators to 0. ovf is cleared.
- IDLE → DONE directly when start is high with k_len=0. C is then 0 (acc_mode=0) or unchanged (acc_mode=1).
- In LOAD, in_ready=1. On each accepted beat, every C[i][j] += ext(a_col[i]) · ext(b_row[j]), and the counter increments.
- ext(): sign-extends when signed_mode=1, zero-extends otherwise. The product is 2·DATA_W wide and is extended to ACC_W in the same mode.
- Addition wraps modulo 2^ACC_W. ovf is set if any add overflows: signed overflow in signed mode, carry-out in unsigned mode. ovf holds until the next start.
- LOAD → DONE on the edge that accepts beat number k_len. DONE → IDLE unconditionally after one cycle.
- in_ready=0 in IDLE and DONE. in_valid outside LOAD is ignored.
- start outside IDLE is ignored, including start in DONE.
- c_out is driven directly from the accumulator registers. It is stable from done until the next accepted beat or clearing start.

## Timing
- Reset values: state IDLE, accumulators 0 (c_out=0), in_ready=0, busy=0, done=0, ovf=0, counter 0.
- Reset mid-job: the job is abandoned immediately, with all state at reset values. No done pulse is generated.
- Latency: done is high in the cycle after the final beat handshake. k_len=0 gives done in the cycle after start.
- Throughput: one beat per cycle; in_valid gaps stall with no penalty.
- Back-to-back jobs: the earliest next start is the cycle after done. Minimum job period is k_len+2 cycles.
- Single-cycle multiply-add per beat; no internal pipelining of the MAC.

## Test plan
- Basic, N=2, signed, acc_mode=0, k_len=2. Beats: a_col={1,3}, b_row={5,6}, then a_col={2,4}, b_row={7,8}. Required: C={{19,22},{43,50}}, done exactly 1 cycle after beat 2, ovf=0.
- Accumulate: repeat the basic job with acc_mode=1. Required: C={{38,44},{86,100}}.
- Signed operands, A={{-1,2},{3,-4}}, B={{5,6},{7,8}}. Required: C={{9,10},{-13,-14}}. With acc_mode=0, any prior result is cleared.
- Unsigned extremes, signed_mode=0, k_len=1, all operands 8'hFF. Required: every C=65025. Same operands with signed_mode=1: every C=1.
- Handshake gaps: the basic job with in_valid low for 3 cycles between beats, and start/in_valid pulsed in IDLE or DONE. Required: same C, done 1 cycle after the last beat, ignored inputs have no effect.
- Edge cases:
  - k_len=0 with acc_mode=1: C unchanged, done 1 cycle after start.
  - ACC_W=16, k_len=3, signed, 127·127 on all beats: ovf=1.
  - rst asserted after beat 1: all outputs return to 0, no done pulse.
